// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline types: datapath width, register address width and
// the MEM/WB and writeback-forwarding payloads.
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic reg_write;
        logic branch;
    } ctrl_t;

    typedef struct packed {
        logic [XLEN-1:0]       alu_result;
        logic [XLEN-1:0]       mem_data;
        logic [REG_ADDR_W-1:0] rd_addr;
        ctrl_t                 ctrl;
        logic                  valid_mem_wb;
    } mem_wb_reg_t;

    // Writeback forwarding source as seen by the hazard/forwarding unit.
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_fwd_t;

endpackage

// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB register with stall/flush, writeback mux, register
// file write port, WB forwarding source, retire strobe and instret counter.
module wb_stage
    import riscv_pkg::*;
#(
    parameter int INSTRET_W = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  mem_wb_reg_t           mem_wb_in,
    input  logic                  stall,
    input  logic                  flush,
    output logic                  rf_wr_en,
    output logic [REG_ADDR_W-1:0] rf_wr_addr,
    output logic [XLEN-1:0]       rf_wr_data,
    output logic                  fwd_valid,
    output logic [REG_ADDR_W-1:0] fwd_rd,
    output logic [XLEN-1:0]       fwd_data,
    output logic                  retire_valid,
    output logic [REG_ADDR_W-1:0] retire_rd,
    output logic [INSTRET_W-1:0]  instret
);

    mem_wb_reg_t          r_q;
    logic                 done_q;
    logic [INSTRET_W-1:0] instret_q;

    logic [XLEN-1:0] wb_data;
    logic            wr_ok;
    wb_fwd_t         fwd;
    logic            unused_ctrl;

    // Store/branch qualifiers travel with the entry but do not affect writeback.
    assign unused_ctrl = r_q.ctrl.mem_write ^ r_q.ctrl.branch;

    always_comb begin
        wb_data      = r_q.ctrl.mem_read ? r_q.mem_data : r_q.alu_result;
        wr_ok        = r_q.valid_mem_wb & r_q.ctrl.reg_write & (r_q.rd_addr != '0);
        fwd          = '{valid: wr_ok, rd: r_q.rd_addr, data: wb_data};
        // done_q suppresses repeat commits of a held entry; forwarding ignores it.
        rf_wr_en     = wr_ok & ~done_q;
        rf_wr_addr   = r_q.rd_addr;
        rf_wr_data   = wb_data;
        fwd_valid    = fwd.valid;
        fwd_rd       = fwd.rd;
        fwd_data     = fwd.data;
        retire_valid = r_q.valid_mem_wb & ~done_q;
        retire_rd    = wr_ok ? r_q.rd_addr : '0;
        instret      = instret_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q       <= '0;
            done_q    <= 1'b0;
            instret_q <= '0;
        end else begin
            if (retire_valid) begin
                instret_q <= instret_q + INSTRET_W'(1);
            end
            if (flush) begin
                r_q    <= '0;
                done_q <= 1'b0;
            end else if (stall) begin
                done_q <= done_q | retire_valid;
            end else begin
                r_q    <= mem_wb_in;
                done_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Randomized scoreboard bench for wb_stage: every accepted instruction queues
// its expected retire; a negedge monitor pops on each retire strobe.
module tb_wb_stage;
    import riscv_pkg::*;

    localparam int IW = 4;

    logic                  clk = 1'b0;
    logic                  reset;
    mem_wb_reg_t           mem_wb_in;
    logic                  stall;
    logic                  flush;
    logic                  rf_wr_en;
    logic [REG_ADDR_W-1:0] rf_wr_addr;
    logic [XLEN-1:0]       rf_wr_data;
    logic                  fwd_valid;
    logic [REG_ADDR_W-1:0] fwd_rd;
    logic [XLEN-1:0]       fwd_data;
    logic                  retire_valid;
    logic [REG_ADDR_W-1:0] retire_rd;
    logic [IW-1:0]         instret;

    wb_stage #(.INSTRET_W(IW)) dut (
        .clk(clk), .reset(reset), .mem_wb_in(mem_wb_in), .stall(stall), .flush(flush),
        .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .retire_valid(retire_valid), .retire_rd(retire_rd), .instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]      rd;
        logic            wr;
        logic [XLEN-1:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    mem_wb_reg_t m_cur;
    bit          m_retired;
    int unsigned m_count;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic mem_wb_reg_t mk(input bit v, input bit mr, input bit rw,
                                        input logic [4:0] rd, input logic [31:0] md,
                                        input logic [31:0] alu);
        mem_wb_reg_t e;
        e = '0;
        e.valid_mem_wb   = v;
        e.ctrl.mem_read  = mr;
        e.ctrl.reg_write = rw;
        e.ctrl.mem_write = !rw && mr == 1'b0 && $urandom_range(0, 1) == 1;
        e.rd_addr        = rd;
        e.mem_data       = md;
        e.alu_result     = alu;
        return e;
    endfunction

    function automatic mem_wb_reg_t rnd();
        logic [4:0] rd;
        rd = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
        return mk($urandom_range(0, 9) < 8, 1'($urandom), $urandom_range(0, 3) != 0,
                  rd, $urandom, $urandom);
    endfunction

    // What an instruction must show on retire, straight from the ISA rules.
    function automatic exp_t expect_of(input mem_wb_reg_t e);
        exp_t x;
        x.wr   = e.ctrl.reg_write && e.rd_addr != 0;
        x.rd   = x.wr ? e.rd_addr : 5'd0;
        x.data = e.ctrl.mem_read ? e.mem_data : e.alu_result;
        return x;
    endfunction

    task automatic model_reset();
        m_cur     = '0;
        m_retired = 0;
        m_count   = 0;
        exp_q.delete();
    endtask

    // Each valid instruction retires exactly once, in its first cycle in WB.
    task automatic model_edge(input bit s, input bit f, input mem_wb_reg_t in);
        if (m_cur.valid_mem_wb && !m_retired) m_count++;
        if (f) begin
            m_cur     = '0;
            m_retired = 0;
        end else if (s) begin
            m_retired = m_retired || m_cur.valid_mem_wb;
        end else begin
            m_cur     = in;
            m_retired = 0;
            if (in.valid_mem_wb) exp_q.push_back(expect_of(in));
        end
    endtask

    task automatic cycle(input bit s, input bit f, input mem_wb_reg_t in);
        stall     = s;
        flush     = f;
        mem_wb_in = in;
        @(posedge clk);
        model_edge(s, f, in);
        #1;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            logic exp_fv;
            exp_t e;
            if (retire_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_retire actual=1 required=0");
                end else begin
                    e = exp_q.pop_front();
                    chk("retire_rd", retire_rd, e.rd);
                    chk("rf_wr_en", rf_wr_en, e.wr);
                    if (e.wr) begin
                        chk("rf_wr_addr", rf_wr_addr, e.rd);
                        chk("rf_wr_data", rf_wr_data, e.data);
                    end
                    $display("retire t=%0t rd=%0d wr=%0b data=%08h instret=%0d",
                             $time, retire_rd, rf_wr_en, rf_wr_data, instret);
                end
            end else begin
                chk("wr_without_retire", rf_wr_en, 1'b0);
            end
            chk("instret", instret, m_count % (1 << IW));
            exp_fv = m_cur.valid_mem_wb && m_cur.ctrl.reg_write && m_cur.rd_addr != 0;
            chk("fwd_valid", fwd_valid, exp_fv);
            if (exp_fv) begin
                chk("fwd_rd", fwd_rd, m_cur.rd_addr);
                chk("fwd_data", fwd_data, m_cur.ctrl.mem_read ? m_cur.mem_data : m_cur.alu_result);
            end
        end
    end

    initial begin
        reset     = 1'b1;
        stall     = 1'b0;
        flush     = 1'b0;
        mem_wb_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_instret", instret, '0);
        chk("reset_retire", retire_valid, 1'b0);
        reset = 1'b0;
        repeat (2) cycle(0, 0, '0);

        // load from memory
        cycle(0, 0, mk(1, 1, 1, 5'd5, 32'hDEADBEEF, 32'h100));
        // ALU write to x0 is suppressed but still retires
        cycle(0, 0, mk(1, 0, 1, 5'd0, 32'h0, 32'h7));
        // one retire across a 3-cycle stall, forwarding held throughout
        cycle(0, 0, mk(1, 0, 1, 5'd3, 32'h0, 32'h2A));
        repeat (3) cycle(1, 0, rnd());
        // flush beats stall
        cycle(1, 1, mk(1, 0, 1, 5'd9, 32'h0, 32'h55));
        chk("flush_bubble_fwd", fwd_valid, 1'b0);
        chk("flush_bubble_retire", retire_valid, 1'b0);
        cycle(0, 0, '0);

        // reset mid-cycle while a stalled entry is held
        cycle(0, 0, mk(1, 0, 1, 5'd7, 32'h0, 32'h77));
        cycle(1, 0, rnd());
        #1;
        reset = 1'b1;
        #1;
        chk("midreset_rf_wr_en", rf_wr_en, 1'b0);
        chk("midreset_retire", retire_valid, 1'b0);
        chk("midreset_instret", instret, '0);
        chk("midreset_fwd", fwd_valid, 1'b0);
        reset = 1'b0;
        model_reset();
        repeat (2) cycle(0, 0, '0);

        // randomized traffic; 4-bit instret wraps several times
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0, rnd());
        end
        repeat (3) cycle(0, 0, '0);
        chk("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage; sits directly downstream of the memory stage and consumes its mem_wb_reg_t output.
- Owns the MEM/WB pipeline register with stall and flush, the writeback data mux, and the register-file write port.
- Drives the WB-to-ID/EX forwarding path, a one-pulse-per-instruction retire strobe, and the instruction-retired counter.

Parameters:
INSTRET_W  64  width of the retired-instruction counter; wraps modulo 2^INSTRET_W
XLEN  (riscv_pkg)  datapath width, taken from the package, not overridable here

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state
mem_wb_in  input  mem_wb_reg_t  MEM stage output: alu_result, mem_data, rd_addr, ctrl, valid_mem_wb
stall  input  1  hold the MEM/WB register contents
flush  input  1  load a bubble into the MEM/WB register
rf_wr_en  output  1  register-file write enable
rf_wr_addr  output  5  register-file write address
rf_wr_data  output  XLEN  register-file write data
fwd_valid  output  1  forwarding source is valid
fwd_rd  output  5  forwarding destination register
fwd_data  output  XLEN  forwarding value
retire_valid  output  1  one-cycle pulse, one per committed instruction
retire_rd  output  5  rd of the retiring instruction (0 if no reg write)
instret  output  INSTRET_W  count of retired instructions

Behaviour:
- Reset (async, active-high) forces r.valid=0, all r fields 0, done=0, instret=0.
  - Consequently rf_wr_en=0, fwd_valid=0, retire_valid=0, all data/addr outputs 0 while reset is asserted and after release until a valid load.
- MEM/WB register r, updated on the rising clk edge:
  - flush=1: r.valid<=0; other fields don't care (zero them). Flush has priority over stall.
  - else stall=1: r holds.
  - else: r<=mem_wb_in.
- Flag done:
  - Set to 1 on any edge where r holds a valid entry and it has already retired this cycle (retire_valid=1), and r is held (stall=1, flush=0).
  - Cleared whenever r is loaded (no stall) or flushed.
  - Guarantees exactly one retire and one RF write per instruction across multi-cycle stalls.
- wb_data = r.ctrl.mem_read ? r.mem_data : r.alu_result. All combinational from r; one-cycle latency from mem_wb_in to the RF write.
- wr_ok = r.valid_mem_wb & r.ctrl.reg_write & (r.rd_addr != 0). Writes to x0 are always suppressed.
- RF write port: rf_wr_en = wr_ok & ~done; rf_wr_addr = r.rd_addr; rf_wr_data = wb_data.
- Forwarding: fwd_valid = wr_ok, not gated by done, so stalled consumers still see the value; fwd_rd = r.rd_addr; fwd_data = wb_data.
- Retire:
  - retire_valid = r.valid_mem_wb & ~done.
  - retire_rd = wr_ok ? r.rd_addr : 0.
  - Stores and branches retire without writing.
- instret increments by 1 on each edge with retire_valid=1; wraps from all-ones to 0 with no flag.
- Simultaneous events:
  - flush together with retire_valid: the current entry still retires this cycle (its outputs are combinational from r); the bubble arrives next cycle.
  - stall on a bubble: nothing retires.
- Reset mid-stall discards the held entry; instret=0 with no partial retire.

Decomposition:
- riscv_pkg already holds mem_wb_reg_t, ctrl_t, XLEN.
- Add to riscv_pkg: REG_ADDR_W=5 and a wb_fwd_t struct {valid, rd, data}, shared with the hazard/forwarding unit.
- No sub-module. The pipeline register, done flag and counter stay in one always_ff; muxing stays in one always_comb.

Test Plan:
1. Reset asserted mid-cycle with a valid entry in r -> immediately rf_wr_en=0, retire_valid=0, instret=0. After release with no valid input, outputs stay 0.
2. Load with valid=1, mem_read=1, reg_write=1, rd=5, mem_data=0xDEADBEEF, alu_result=0x100 -> next cycle rf_wr_en=1, addr=5, data=0xDEADBEEF, retire_valid=1, instret=1.
3. ALU op with rd=0, reg_write=1, alu_result=0x7 -> rf_wr_en=0, fwd_valid=0, retire_valid=1, retire_rd=0, instret increments.
4. Valid ALU op rd=3, data=0x2A, then stall held 3 cycles -> exactly one rf_wr_en/retire_valid pulse (first cycle); fwd_valid=1 with fwd_data=0x2A on all 4 cycles; instret +1 only.
5. flush and stall asserted together while mem_wb_in is valid -> next cycle r.valid=0, no write, no retire; done cleared.
6. Preload instret to all-ones (force, or INSTRET_W=4 with 15 retires), then one more retire -> instret=0, no other side effect.
